// File: rtl/dp_deparser.sv
// Egress deparser: applies the match-action verdict to each buffered packet, rewriting the
// Ethernet/IPv4 header bytes of forwarded packets and silently consuming dropped ones.
module dp_deparser #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned HDR_BYTES  = 34
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic                    dec_drop,
    input  logic [HDR_BYTES*8-1:0]  hdr_in,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [31:0]             pass_count,
    output logic [31:0]             drop_count
);

    localparam int unsigned HDR_W     = HDR_BYTES * 8;
    localparam int unsigned ETH_BYTES = 14;
    localparam int unsigned HDR_BEATS = (HDR_BYTES + KEEP_WIDTH - 1) / KEEP_WIDTH;
    localparam int unsigned BW        = $clog2(HDR_BEATS + 1);
    localparam int unsigned ETYPE_MSB = (HDR_BYTES - 12) * 8 - 1;
    localparam logic [15:0] ETH_IPV4  = 16'h0800;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FORWARD,
        S_DROP
    } state_e;

    state_e                  state_q, state_d;
    logic [HDR_W-1:0]        hdr_q, hdr_d;
    logic [BW-1:0]           beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
    logic [KEEP_WIDTH-1:0]   m_tkeep_q, m_tkeep_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic                    m_tlast_q, m_tlast_d;
    logic                    dec_ready_q, dec_ready_d;
    logic [31:0]             pass_q, pass_d;
    logic [31:0]             drop_q, drop_d;
    logic                    is_ipv4;
    logic                    beat_acc;
    logic [DATA_WIDTH-1:0]   rw_data;

    assign is_ipv4 = (hdr_q[ETYPE_MSB -: 16] == ETH_IPV4);

    // Per-lane header overwrite keyed on the byte's position within the packet.
    always_comb begin : rewrite
        int unsigned idx;
        int unsigned k;
        idx     = 32'd0;
        k       = 32'd0;
        rw_data = s_axis_tdata;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            idx = 32'(beat_cnt_q) * KEEP_WIDTH + i;
            k   = (idx < HDR_BYTES) ? idx : 32'd0;
            if (idx < ETH_BYTES || (is_ipv4 && idx < HDR_BYTES)) begin
                rw_data[i*8 +: 8] = hdr_q[(HDR_BYTES - 1 - k) * 8 +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        beat_cnt_d    = beat_cnt_q;
        m_tdata_d     = m_tdata_q;
        m_tkeep_d     = m_tkeep_q;
        m_tvalid_d    = m_tvalid_q;
        m_tlast_d     = m_tlast_q;
        dec_ready_d   = 1'b0;
        pass_d        = pass_q;
        drop_d        = drop_q;
        s_axis_tready = 1'b0;

        case (state_q)
            S_FORWARD: s_axis_tready = !m_tvalid_q || m_axis_tready;
            S_DROP:    s_axis_tready = 1'b1;
            default:   s_axis_tready = 1'b0;
        endcase
        beat_acc = s_axis_tvalid && s_axis_tready;

        // Output register drains independently of the FSM, including while idle.
        if (m_tvalid_q && m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end

        if (beat_acc && beat_cnt_q != BW'(HDR_BEATS)) begin
            beat_cnt_d = beat_cnt_q + BW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (dec_valid) begin
                    hdr_d       = hdr_in;
                    dec_ready_d = 1'b1;
                    beat_cnt_d  = '0;
                    state_d     = dec_drop ? S_DROP : S_FORWARD;
                end
            end
            S_FORWARD: begin
                if (beat_acc) begin
                    m_tdata_d  = rw_data;
                    m_tkeep_d  = s_axis_tkeep;
                    m_tlast_d  = s_axis_tlast;
                    m_tvalid_d = 1'b1;
                    if (s_axis_tlast) begin
                        pass_d  = pass_q + 32'd1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                if (beat_acc && s_axis_tlast) begin
                    drop_d  = drop_q + 32'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            beat_cnt_q  <= '0;
            m_tdata_q   <= '0;
            m_tkeep_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            dec_ready_q <= 1'b0;
            pass_q      <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            beat_cnt_q  <= beat_cnt_d;
            m_tdata_q   <= m_tdata_d;
            m_tkeep_q   <= m_tkeep_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            dec_ready_q <= dec_ready_d;
            pass_q      <= pass_d;
            drop_q      <= drop_d;
        end
    end

    assign dec_ready     = dec_ready_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign pass_count    = pass_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_dp_deparser.sv
// Scoreboard bench for dp_deparser: drivers queue expected beats, a negedge monitor checks them.
module tb_dp_deparser;

    logic          clk = 1'b0;
    logic          rst;
    logic          dec_valid;
    logic          dec_ready;
    logic          dec_drop;
    logic [271:0]  hdr_in;
    logic [63:0]   s_axis_tdata;
    logic [7:0]    s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [63:0]   m_axis_tdata;
    logic [7:0]    m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [31:0]   pass_count;
    logic [31:0]   drop_count;

    dp_deparser dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_drop(dec_drop), .hdr_in(hdr_in),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .pass_count(pass_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t         exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic          mon_en = 1'b1;
    logic          tog_mode = 1'b0;
    int            ready_pulses = 0;
    int            valid_cycles = 0;
    int            out_beats = 0;
    int            stalls = 0;
    logic [7:0]    cap[0:127];
    logic          vdrop[0:3];
    logic [271:0]  vhdr[0:3];
    int            plen[0:3];

    logic [271:0]  hdr_v4;
    logic [271:0]  hdr_v6;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pkt_byte(input int s, input int i);
        return 8'(i * 5 + 17 + s * 3);
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [271:0] h, input int k);
        logic [271:0] t;
        t = h >> (8 * (33 - k));
        return t[7:0];
    endfunction

    // Independent reference: what each output byte must be, from packet position and ethtype.
    task automatic push_expected(input int p);
        int    nb;
        int    idx;
        beat_t b;
        logic  v4;
        v4 = (hdr_byte(vhdr[p], 12) == 8'h08) && (hdr_byte(vhdr[p], 13) == 8'h00);
        nb = (plen[p] + 7) / 8;
        for (int bi = 0; bi < nb; bi++) begin
            b = '0;
            for (int ln = 0; ln < 8; ln++) begin
                idx = bi * 8 + ln;
                if (idx < plen[p]) begin
                    b.k[ln] = 1'b1;
                    if (idx < 14 || (v4 && idx < 34)) b.d[ln*8 +: 8] = hdr_byte(vhdr[p], idx);
                    else                              b.d[ln*8 +: 8] = pkt_byte(p, idx);
                end
            end
            b.l = (bi == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    // Monitor: every output transfer is checked against the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        logic [63:0] mask;
        if (dec_ready) ready_pulses++;
        if (m_axis_tvalid) valid_cycles++;
        if (!rst && mon_en && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {63'd0, m_axis_tvalid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                mask = '0;
                for (int ln = 0; ln < 8; ln++) if (e.k[ln]) mask[ln*8 +: 8] = 8'hFF;
                chk("beat_data", m_axis_tdata & mask, e.d);
                chk("beat_keep", {56'd0, m_axis_tkeep}, {56'd0, e.k});
                chk("beat_last", {63'd0, m_axis_tlast}, {63'd0, e.l});
            end
            if (out_beats < 16) begin
                for (int ln = 0; ln < 8; ln++) cap[out_beats*8 + ln] = m_axis_tdata[ln*8 +: 8];
            end
            out_beats++;
        end
    end

    always @(posedge clk) begin
        #1;
        m_axis_tready = tog_mode ? ~m_axis_tready : 1'b1;
    end

    task automatic do_reset();
        dec_valid     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        ready_pulses = 0;
        valid_cycles = 0;
        out_beats    = 0;
        stalls       = 0;
    endtask

    task automatic send_verdicts(input int n);
        int cyc;
        for (int v = 0; v < n; v++) begin
            dec_valid = 1'b1;
            dec_drop  = vdrop[v];
            hdr_in    = vhdr[v];
            cyc = 0;
            forever begin
                @(negedge clk);
                if (dec_ready) break;
                cyc++;
                if (cyc > 500) begin
                    chk("verdict_timeout", 64'd1, 64'd0);
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        dec_valid = 1'b0;
    endtask

    task automatic set_beat(input int p, input int bi);
        int idx;
        int nb;
        nb = (plen[p] + 7) / 8;
        for (int ln = 0; ln < 8; ln++) begin
            idx = bi * 8 + ln;
            s_axis_tdata[ln*8 +: 8] = (idx < plen[p]) ? pkt_byte(p, idx) : 8'h00;
            s_axis_tkeep[ln]        = (idx < plen[p]);
        end
        s_axis_tlast  = (bi == nb - 1);
        s_axis_tvalid = 1'b1;
    endtask

    task automatic send_stream(input int n);
        int cyc;
        for (int p = 0; p < n; p++) begin
            for (int bi = 0; bi < (plen[p] + 7) / 8; bi++) begin
                set_beat(p, bi);
                cyc = 0;
                forever begin
                    @(negedge clk);
                    if (s_axis_tready) break;
                    if (bi > 0) stalls++;
                    cyc++;
                    if (cyc > 500) begin
                        chk("stream_timeout", 64'd1, 64'd0);
                        break;
                    end
                end
                @(posedge clk);
                #1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic run(input int n);
        int cyc;
        for (int p = 0; p < n; p++) if (!vdrop[p]) push_expected(p);
        fork
            send_verdicts(n);
            send_stream(n);
        join
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        hdr_v4 = {48'h0211_2233_4455, 48'h0A0B_0C0D_0E0F, 16'h0800, 8'h45, 6'h00, 2'b00,
                  16'd50, 16'h1234, 16'h4000, 8'h3F, 8'h06, 16'hBEEF, 32'hAC11_0115, 32'h0A00_0001};
        hdr_v6 = {48'h6655_4433_2211, 48'h1122_3344_5566, 16'h86DD, 8'h60, 6'h2A, 2'b01,
                  16'd99, 16'hCAFE, 16'h0000, 8'h11, 8'h11, 16'h0F0F, 32'h1111_2222, 32'h3333_4444};
        m_axis_tready = 1'b1;
        dec_drop      = 1'b0;
        hdr_in        = '0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        do_reset();

        @(negedge clk);
        chk("rst_m_tvalid",   {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_s_tready",   {63'd0, s_axis_tready}, 64'd0);
        chk("rst_dec_ready",  {63'd0, dec_ready},     64'd0);
        chk("rst_pass_count", 64'(pass_count),        64'd0);
        chk("rst_drop_count", 64'(drop_count),        64'd0);

        // 64-byte IPv4 forward.
        @(posedge clk); #1;
        vdrop[0] = 1'b0; vhdr[0] = hdr_v4; plen[0] = 64;
        run(1);
        chk("v4_beats",      64'(out_beats),  64'd8);
        chk("v4_pass",       64'(pass_count), 64'd1);
        chk("v4_byte0",      {56'd0, cap[0]},  64'h02);
        chk("v4_ttl",        {56'd0, cap[22]}, 64'h3F);
        chk("v4_src0",       {56'd0, cap[26]}, 64'hAC);
        chk("v4_src1",       {56'd0, cap[27]}, 64'h11);
        chk("v4_src2",       {56'd0, cap[28]}, 64'h01);
        chk("v4_src3",       {56'd0, cap[29]}, 64'h15);
        chk("v4_byte40",     {56'd0, cap[40]}, 64'hD9);
        chk("v4_byte63",     {56'd0, cap[63]}, 64'h4C);

        // 8-beat drop: no output, one beat per cycle.
        do_reset();
        vdrop[0] = 1'b1; vhdr[0] = hdr_v4; plen[0] = 64;
        run(1);
        chk("drop_valid_cycles", 64'(valid_cycles), 64'd0);
        chk("drop_stalls",       64'(stalls),       64'd0);
        chk("drop_count",        64'(drop_count),   64'd1);
        chk("drop_pass",         64'(pass_count),   64'd0);

        // Non-IPv4 ethtype: only the Ethernet header changes.
        do_reset();
        vdrop[0] = 1'b0; vhdr[0] = hdr_v6; plen[0] = 64;
        run(1);
        chk("v6_etype_hi", {56'd0, cap[12]}, 64'h86);
        chk("v6_etype_lo", {56'd0, cap[13]}, 64'hDD);
        chk("v6_byte14",   {56'd0, cap[14]}, 64'h57);
        chk("v6_byte33",   {56'd0, cap[33]}, 64'hB6);

        // Backpressure toggling every cycle.
        do_reset();
        tog_mode = 1'b1;
        vdrop[0] = 1'b0; vhdr[0] = hdr_v4; plen[0] = 64;
        run(1);
        tog_mode = 1'b0;
        chk("tog_beats", 64'(out_beats),  64'd8);
        chk("tog_ttl",   {56'd0, cap[22]}, 64'h3F);
        chk("tog_pass",  64'(pass_count), 64'd1);

        // Back-to-back pass, drop, short pass with dec_valid held throughout.
        do_reset();
        vdrop[0] = 1'b0; vhdr[0] = hdr_v4; plen[0] = 64;
        vdrop[1] = 1'b1; vhdr[1] = hdr_v6; plen[1] = 64;
        vdrop[2] = 1'b0; vhdr[2] = hdr_v6; plen[2] = 20;
        run(3);
        chk("b2b_ready_pulses", 64'(ready_pulses), 64'd3);
        chk("b2b_beats",        64'(out_beats),    64'd11);
        chk("b2b_pass",         64'(pass_count),   64'd2);
        chk("b2b_drop",         64'(drop_count),   64'd1);

        // Single-beat packet.
        do_reset();
        vdrop[0] = 1'b0; vhdr[0] = hdr_v4; plen[0] = 6;
        run(1);
        chk("single_beats", 64'(out_beats),  64'd1);
        chk("single_pass",  64'(pass_count), 64'd1);

        // Reset mid-packet on beat 3.
        do_reset();
        mon_en   = 1'b0;
        vdrop[0] = 1'b0; vhdr[0] = hdr_v4; plen[0] = 64;
        send_verdicts(1);
        for (int bi = 0; bi < 3; bi++) begin
            set_beat(0, bi);
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (s_axis_tready) break;
            end
            @(posedge clk);
            #1;
        end
        set_beat(0, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_m_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("midrst_s_tready", {63'd0, s_axis_tready}, 64'd0);
        chk("midrst_pass",     64'(pass_count),        64'd0);
        repeat (2) @(negedge clk);
        chk("midrst_idle", {63'd0, s_axis_tready}, 64'd0);
        s_axis_tvalid = 1'b0;
        mon_en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
